// File: rtl/rs_ino_entry_ctrl_if.sv
// Dispatch/issue/branch-resolution bundle for the in-order reservation station entry controller.
// The master side drives requests; the slave side (entry controller) returns the entry vectors.
interface rs_ino_entry_ctrl_if #(
  parameter int ENTSEL      = 2,
  parameter int ENTNUM      = 4,
  parameter int SPECTAG_LEN = 5
);
  logic [ENTSEL-1:0]      allocptr;
  logic [1:0]             reqnum;
  logic                   alloc_en;
  logic [SPECTAG_LEN-1:0] specmask1;
  logic [SPECTAG_LEN-1:0] specmask2;
  logic                   rdy1;
  logic                   rdy2;
  logic [ENTNUM-1:0]      wakeup_vec;
  logic                   issue_en;
  logic [ENTSEL-1:0]      issueptr;
  logic                   prmiss;
  logic                   prsuccess;
  logic [SPECTAG_LEN-1:0] prtag;
  logic [ENTNUM-1:0]      busyvec;
  logic [ENTNUM-1:0]      prbusyvec_next;
  logic [ENTNUM-1:0]      readyvec;
  logic [ENTSEL:0]        count;
  logic                   err;

  modport master (
    output allocptr, reqnum, alloc_en, specmask1, specmask2, rdy1, rdy2,
           wakeup_vec, issue_en, issueptr, prmiss, prsuccess, prtag,
    input  busyvec, prbusyvec_next, readyvec, count, err
  );

  modport slave (
    input  allocptr, reqnum, alloc_en, specmask1, specmask2, rdy1, rdy2,
           wakeup_vec, issue_en, issueptr, prmiss, prsuccess, prtag,
    output busyvec, prbusyvec_next, readyvec, count, err
  );
endinterface

// File: rtl/rs_ino_entry_ctrl.sv
// Per-entry busy/ready/speculative-mask state of an in-order reservation station ring.
// Handles dispatch, issue, operand wakeup, mispredict squash and branch-success tag resolution.
module rs_ino_entry_ctrl #(
  parameter int ENTSEL      = 2,
  parameter int ENTNUM      = 4,
  parameter int SPECTAG_LEN = 5
) (
  input  logic               clk,
  input  logic               reset,
  rs_ino_entry_ctrl_if.slave bus
);

  logic [ENTNUM-1:0]      r_busy;
  logic [ENTNUM-1:0]      r_rdy;
  logic [SPECTAG_LEN-1:0] r_mask [ENTNUM];
  logic [ENTSEL:0]        r_count;
  logic                   r_err;

  logic [ENTNUM-1:0]      w_kill;
  logic [ENTNUM-1:0]      w_prbusy;
  logic [ENTNUM-1:0]      w_sel1;
  logic [ENTNUM-1:0]      w_sel2;
  logic [ENTNUM-1:0]      w_busy_nx;
  logic [ENTNUM-1:0]      w_rdy_nx;
  logic [SPECTAG_LEN-1:0] w_mask_nx [ENTNUM];
  logic [SPECTAG_LEN-1:0] w_clr;
  logic [ENTSEL-1:0]      w_ptr2;
  logic [ENTSEL:0]        w_count_nx;
  logic                   w_alloc;
  logic                   w_err_ev;

  function automatic logic is_onehot(input logic [SPECTAG_LEN-1:0] v);
    return (v != '0) && ((v & (v - SPECTAG_LEN'(1))) == '0);
  endfunction

  // Squash selection and allocation targets; a mispredict drops the whole dispatch group.
  always_comb begin
    w_alloc = bus.alloc_en && !bus.prmiss;
    w_clr   = (bus.prsuccess && !bus.prmiss) ? bus.prtag : '0;
    w_ptr2  = bus.allocptr + ENTSEL'(1);
    for (int i = 0; i < ENTNUM; i++) begin
      w_kill[i] = r_busy[i] && (|(r_mask[i] & bus.prtag));
      w_sel1[i] = w_alloc && (bus.reqnum != 2'd0) && (bus.allocptr == ENTSEL'(i));
      w_sel2[i] = w_alloc && (bus.reqnum == 2'd2) && (w_ptr2 == ENTSEL'(i));
    end
    w_prbusy = bus.prmiss ? (r_busy & ~w_kill) : r_busy;
  end

  always_comb begin
    w_count_nx = '0;
    for (int i = 0; i < ENTNUM; i++) begin
      if (w_sel1[i]) begin
        w_busy_nx[i] = 1'b1;
        w_rdy_nx[i]  = bus.rdy1;
        w_mask_nx[i] = bus.specmask1 & ~w_clr;
      end else if (w_sel2[i]) begin
        w_busy_nx[i] = 1'b1;
        w_rdy_nx[i]  = bus.rdy2;
        w_mask_nx[i] = bus.specmask2 & ~w_clr;
      end else if (bus.issue_en && (bus.issueptr == ENTSEL'(i))) begin
        w_busy_nx[i] = 1'b0;
        w_rdy_nx[i]  = 1'b0;
        w_mask_nx[i] = r_mask[i] & ~w_clr;
      end else begin
        // Ready only survives on entries that are still busy after any squash.
        w_busy_nx[i] = w_prbusy[i];
        w_rdy_nx[i]  = (r_rdy[i] || (bus.wakeup_vec[i] && r_busy[i])) && w_prbusy[i];
        w_mask_nx[i] = r_mask[i] & ~w_clr;
      end
      w_count_nx = w_count_nx + (ENTSEL+1)'(w_busy_nx[i]);
    end
    w_err_ev = (|((w_sel1 | w_sel2) & r_busy))
            || (bus.alloc_en && (bus.reqnum == 2'd3))
            || (bus.issue_en && !r_busy[bus.issueptr])
            || ((bus.prmiss || bus.prsuccess) && !is_onehot(bus.prtag));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= '0;
      r_rdy   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < ENTNUM; i++) begin
        r_mask[i] <= '0;
      end
    end else begin
      r_busy  <= w_busy_nx;
      r_rdy   <= w_rdy_nx;
      r_count <= w_count_nx;
      r_err   <= r_err | w_err_ev;
      for (int i = 0; i < ENTNUM; i++) begin
        r_mask[i] <= w_mask_nx[i];
      end
    end
  end

  assign bus.busyvec        = r_busy;
  assign bus.readyvec       = r_busy & r_rdy;
  assign bus.prbusyvec_next = w_prbusy;
  assign bus.count          = r_count;
  assign bus.err            = r_err;

endmodule
